// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-ported ram: serialises fetch
// and data requests, routes each response back, and times out dead ones.
module mem_arbiter #(
  parameter int TIMEOUT     = 15,
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_valid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            grant;
  logic            last_grant;
  logic [CW-1:0]   cnt;
  logic            req;
  logic            pick;
  logic            tmo;

  assign req = m0_valid | m1_valid;
  assign tmo = (cnt == CNT_LAST);

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (m0_valid && m1_valid):
        pick = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
      (m1_valid && !m0_valid):
        pick = 1'b1;
      default:
        pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (ram_ready || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready has priority over timeout; the idle port's outputs stay untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      ram_valid  <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wstrb  <= '0;
      m0_ready   <= 1'b0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_ready   <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            ram_valid  <= 1'b1;
            ram_addr   <= pick ? m1_addr  : m0_addr;
            ram_wdata  <= pick ? m1_wdata : m0_wdata;
            ram_wstrb  <= pick ? m1_wstrb : m0_wstrb;
            grant      <= pick;
            last_grant <= pick;
            cnt        <= '0;
          end
        end
        BUSY: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (ram_ready) begin
            ram_valid <= 1'b0;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_rdata <= ram_rdata;
              m1_err   <= 1'b0;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= ram_rdata;
              m0_err   <= 1'b0;
            end
          end else if (tmo) begin
            ram_valid <= 1'b0;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_rdata <= '0;
              m1_err   <= 1'b1;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= '0;
              m0_err   <= 1'b1;
            end
          end
        end
        DONE: begin
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported `ram` block between the core's instruction-fetch port (port 0) and data port (port 1). Each requester uses the same valid/ready memory handshake as `ram`. The arbiter serialises requests, drives `ram` one transaction at a time and routes the response back to the granted port. A timeout guarantees completion, with an error flag, when `ram` never asserts ready (out-of-range address).

## Interface
- `TIMEOUT`, 15: BUSY cycles allowed without `ram_ready` before an error response; legal range 2..255.
- `ROUND_ROBIN`, 1: 1 = round-robin on contention; 0 = fixed priority, port 0 wins.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `m0_valid` / `m1_valid` in 1: request from port 0 / port 1.
- `m0_addr` / `m1_addr` in 32: byte address.
- `m0_wdata` / `m1_wdata` in 32: write data.
- `m0_wstrb` / `m1_wstrb` in 4: byte-write strobes; 0 = read.
- `m0_ready` / `m1_ready` out 1: one-cycle completion pulse.
- `m0_rdata` / `m1_rdata` out 32: read data; valid while ready is high.
- `m0_err` / `m1_err` out 1: pulses with ready when the transaction timed out.
- `ram_valid` out 1: request to `ram`.
- `ram_addr` out 32: address to `ram`.
- `ram_wdata` out 32: write data to `ram`.
- `ram_wstrb` out 4: strobes to `ram`.
- `ram_ready` in 1: completion from `ram`.
- `ram_rdata` in 32: read data from `ram`.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal reset state:
  - state = IDLE
  - `last_grant` = 1, so port 0 wins the first tie
  - timeout counter = 0
- **IDLE**
  - No valid: stay in IDLE.
  - Only one port valid: grant that port.
  - Both ports valid, `ROUND_ROBIN`=1: grant the port ≠ `last_grant`.
  - Both ports valid, `ROUND_ROBIN`=0: grant port 0.
  - On grant:
    - latch the granted port's addr/wdata/wstrb into `ram_addr`/`ram_wdata`/`ram_wstrb`
    - set `ram_valid`=1
    - set `grant` and `last_grant` to the granted port
    - clear the counter
    - go to BUSY.
- **BUSY**
  - Counter increments each cycle.
  - If `ram_ready`=1:
    - `ram_valid`←0
    - `mX_ready`←1
    - `mX_rdata`←`ram_rdata` (writes also copy it; masters ignore it)
    - `mX_err`←0
    - go to DONE.
  - Else, if counter == `TIMEOUT`-1:
    - `ram_valid`←0
    - `mX_ready`←1
    - `mX_rdata`←0
    - `mX_err`←1
    - go to DONE.
  - The `ram_ready` check takes precedence over timeout in the same cycle.
- **DONE**
  - Clear `mX_ready` and `mX_err`.
  - Ignore all valids for this cycle; the master is still dropping its valid.
  - Go to IDLE.
- `mX_rdata` holds its value until that port's next completion.
- The non-granted port's ready, err and rdata are never disturbed.
- Master inputs are latched at grant. Changes to addr/data/strb, or dropping valid, during BUSY do not alter or abort the `ram` transaction; ready still pulses.
- `ram_ready` seen in IDLE or DONE is ignored (stale, e.g. after reset).
- Counter width is $clog2(`TIMEOUT`+1). It saturates and never wraps.

## Timing
- Request sampled at edge E0 (IDLE). `ram_valid` is high from E0.
- `ram` asserts ready at E1. The arbiter samples it at E2; `mX_ready` is high for the cycle E2–E3.
- Read latency: `mX_ready` occurs 2 edges after the request is sampled.
- Timeout: `mX_ready`/`mX_err` is high after the edge at which the BUSY counter reaches `TIMEOUT`-1, i.e. `TIMEOUT` edges after E0.
- Throughput: one transaction per 4 cycles (IDLE, BUSY, BUSY, DONE).
- Back-to-back contention alternates ports every 4 cycles in round-robin mode.
- `ram_valid` falls on the same edge `ram_ready` is sampled. `ram` never sees valid && !ready twice for one transaction, so no duplicate writes occur.
- Reset asserted in any state: at the next edge all outputs are 0 and state is IDLE, with no ready pulse to either port. A `ram_ready` arriving one cycle later is ignored.

## Test plan
- **Single read:** `m0_valid`, `m0_addr`=0x10, word 4 = 0xDEADBEEF → `ram_valid` high 2 cycles, `m0_ready` one-cycle pulse 2 edges after the sample, `m0_rdata`=0xDEADBEEF, `m0_err`=0, `m1_ready` stays 0.
- **Byte write:** `m1_valid`, `m1_addr`=0x20, `m1_wdata`=0x11223344, `m1_wstrb`=4'b0010 → `ram` word 8 byte 1 becomes 0x33, other bytes unchanged. Then a `m0` read of 0x20 returns that word.
- **Contention, round-robin:** both valid continuously for 4 transactions from reset → grant order 0,1,0,1, one `mX_ready` every 4 cycles, no overlap.
- **Contention, `ROUND_ROBIN`=0:** both valid continuously → port 0 granted every transaction. `m1_ready` is never asserted until `m0_valid` drops; then port 1 is served.
- **Timeout:** `m0` read of 0x0001_0000 (beyond `MEM_SIZE`) with `TIMEOUT`=15 → `m0_ready`=1 and `m0_err`=1 exactly 15 edges after the sample, `m0_rdata`=0, `ram_valid` low thereafter. A next request to a valid address succeeds normally.
- **Reset mid-BUSY:** assert `reset` one cycle after grant → at the next edge `ram_valid`=0, no ready pulse to either port, and the stale `ram_ready` is ignored. A request after reset completes normally with `last_grant`=1.
